// File: rtl/serial_tx_arbiter_if.sv
// Requester/arbiter bus for serial_tx_arbiter.
//   req0/req1   : requester has a transaction pending
//   a0/a1,d0/d1 : requester address/data, stable while req is high until ack
//   ack0/ack1   : one-cycle pulse, transaction captured
//   done0/done1 : one-cycle pulse, granted frame finished shifting
//   go_out      : load strobe to the serial buffer
//   a_out/d_out : address/data presented to the buffer
//   busy        : arbiter not idle
//   last_grant  : index of the most recent grantee
interface serial_tx_arbiter_if #(
  parameter int SIZE_A = 7,
  parameter int SIZE_D = 8
);
  logic              req0;
  logic              req1;
  logic [SIZE_A-1:0] a0;
  logic [SIZE_A-1:0] a1;
  logic [SIZE_D-1:0] d0;
  logic [SIZE_D-1:0] d1;
  logic              ack0;
  logic              ack1;
  logic              done0;
  logic              done1;
  logic              go_out;
  logic [SIZE_A-1:0] a_out;
  logic [SIZE_D-1:0] d_out;
  logic              busy;
  logic              last_grant;

  modport master (
    output req0, req1, a0, a1, d0, d1,
    input  ack0, ack1, done0, done1, go_out, a_out, d_out, busy, last_grant
  );

  modport slave (
    input  req0, req1, a0, a1, d0, d1,
    output ack0, ack1, done0, done1, go_out, a_out, d_out, busy, last_grant
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a serial transmit buffer from two requesters.
// A grant loads a_out/d_out and pulses go_out plus the winner's ack; the
// frame then shifts for FRAME_CYCLES, done pulses on the first GAP cycle and
// GAP_CYCLES idle cycles separate frames. Requests are sampled only in IDLE.
//   clk_in  : clock
//   reset_n : asynchronous reset, active high (historical name)
//   bus     : requester/buffer bus (slave side), see serial_tx_arbiter_if
module serial_tx_arbiter #(
  parameter int SIZE_A       = 7,
  parameter int SIZE_D       = 8,
  parameter int FRAME_CYCLES = 20,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                clk_in,
  input  logic                reset_n,
  serial_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // SHIFT is entered with FRAME_CYCLES so the go_out cycle plus FRAME_CYCLES
  // shift cycles elapse before GAP; GAP is entered with GAP_CYCLES-1.
  localparam logic [7:0] FRAME_LD = 8'(FRAME_CYCLES);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_go, w_go_nxt;
  logic              r_ack0, w_ack0_nxt;
  logic              r_ack1, w_ack1_nxt;
  logic              r_done0, w_done0_nxt;
  logic              r_done1, w_done1_nxt;
  logic              r_last, w_last_nxt;
  logic [SIZE_A-1:0] r_a, w_a_nxt;
  logic [SIZE_D-1:0] r_d, w_d_nxt;
  logic              w_win;

  // Lone requester wins; on contention the one not granted last time wins.
  assign w_win = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_go_nxt    = 1'b0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_last_nxt  = r_last;
    w_a_nxt     = r_a;
    w_d_nxt     = r_d;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = FRAME_LD;
          w_go_nxt    = 1'b1;
          w_ack0_nxt  = ~w_win;
          w_ack1_nxt  = w_win;
          w_last_nxt  = w_win;
          w_a_nxt     = w_win ? bus.a1 : bus.a0;
          w_d_nxt     = w_win ? bus.d1 : bus.d0;
        end
      end
      SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LD;
          w_done0_nxt = ~r_last;
          w_done1_nxt = r_last;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_go    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_last  <= 1'b1;
      r_a     <= '1;
      r_d     <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_go    <= w_go_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_last  <= w_last_nxt;
      r_a     <= w_a_nxt;
      r_d     <= w_d_nxt;
    end
  end

  assign bus.go_out     = r_go;
  assign bus.ack0       = r_ack0;
  assign bus.ack1       = r_ack1;
  assign bus.done0      = r_done0;
  assign bus.done1      = r_done1;
  assign bus.last_grant = r_last;
  assign bus.a_out      = r_a;
  assign bus.d_out      = r_d;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] a0 = '0, a1 = '0;
  logic [7:0] d0 = '0, d1 = '0;

  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.SIZE_A(7), .SIZE_D(8)) bus0 ();
  serial_tx_arbiter_if #(.SIZE_A(7), .SIZE_D(8)) bus1 ();

  assign bus0.req0 = req0; assign bus0.req1 = req1;
  assign bus0.a0 = a0; assign bus0.a1 = a1; assign bus0.d0 = d0; assign bus0.d1 = d1;
  assign bus1.req0 = req0; assign bus1.req1 = req1;
  assign bus1.a0 = a0; assign bus1.a1 = a1; assign bus1.d0 = d0; assign bus1.d1 = d1;

  serial_tx_arbiter #(.SIZE_A(7), .SIZE_D(8), .FRAME_CYCLES(20), .GAP_CYCLES(2))
    dut0 (.clk_in(clk), .reset_n(rst), .bus(bus0));
  serial_tx_arbiter #(.SIZE_A(7), .SIZE_D(8), .FRAME_CYCLES(2), .GAP_CYCLES(1))
    dut1 (.clk_in(clk), .reset_n(rst), .bus(bus1));

  logic       o_go[2], o_ack0[2], o_ack1[2], o_done0[2], o_done1[2], o_busy[2], o_last[2];
  logic [6:0] o_a[2];
  logic [7:0] o_d[2];
  assign o_go[0] = bus0.go_out;   assign o_go[1] = bus1.go_out;
  assign o_ack0[0] = bus0.ack0;   assign o_ack0[1] = bus1.ack0;
  assign o_ack1[0] = bus0.ack1;   assign o_ack1[1] = bus1.ack1;
  assign o_done0[0] = bus0.done0; assign o_done0[1] = bus1.done0;
  assign o_done1[0] = bus0.done1; assign o_done1[1] = bus1.done1;
  assign o_busy[0] = bus0.busy;   assign o_busy[1] = bus1.busy;
  assign o_last[0] = bus0.last_grant; assign o_last[1] = bus1.last_grant;
  assign o_a[0] = bus0.a_out;     assign o_a[1] = bus1.a_out;
  assign o_d[0] = bus0.d_out;     assign o_d[1] = bus1.d_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic int fc(input int i);
    return (i == 0) ? 20 : 2;
  endfunction
  function automatic int gp(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model: each grant is a set of timestamps. A grant decided at
  // the edge ending cycle c gives go in c+1, done in c+1+FRAME+1 and the
  // first idle cycle c+1+FRAME+GAP+1.
  int         go_c[2], done_c[2], free_c[2];
  bit         m_win[2], m_last[2];
  logic [6:0] m_a[2];
  logic [7:0] m_d[2];

  initial begin
    int  cyc;
    bit  e_go, e_busy, e_done;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          go_c[i] = -1; done_c[i] = -1; free_c[i] = 0;
          m_last[i] = 1'b1; m_win[i] = 1'b1; m_a[i] = 7'h7F; m_d[i] = 8'hFF;
        end
        e_go   = (cyc == go_c[i]);
        e_done = (cyc == done_c[i]);
        e_busy = (go_c[i] >= 0) && (cyc >= go_c[i]) && (cyc < free_c[i]);
        chk("go_out", i, o_go[i], e_go);
        chk("ack0", i, o_ack0[i], e_go && !m_win[i]);
        chk("ack1", i, o_ack1[i], e_go && m_win[i]);
        chk("done0", i, o_done0[i], e_done && !m_win[i]);
        chk("done1", i, o_done1[i], e_done && m_win[i]);
        chk("busy", i, o_busy[i], e_busy);
        chk("last_grant", i, o_last[i], m_last[i]);
        chk("a_out", i, o_a[i], m_a[i]);
        chk("d_out", i, o_d[i], m_d[i]);
        if (!rst && !e_busy && (req0 || req1)) begin
          m_win[i]  = (req0 && req1) ? !m_last[i] : req1;
          m_last[i] = m_win[i];
          m_a[i]    = m_win[i] ? a1 : a0;
          m_d[i]    = m_win[i] ? d1 : d0;
          go_c[i]   = cyc + 1;
          done_c[i] = cyc + 1 + fc(i) + 1;
          free_c[i] = cyc + 1 + fc(i) + gp(i) + 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle0();
    int t;
    t = 0;
    while (bus0.busy && t < 100) begin tick(); t++; end
    chk("idle_wait", 0, bus0.busy, 0);
  endtask

  initial begin
    int         t, ng, n1, d1t, na0, na1, ngo;
    int         gt[4], g1t[2];
    logic       gw[4];

    // Single req0 at defaults, with literal timing pins.
    hold_reset(3);
    chk("rst_a_out", 0, bus0.a_out, 7'h7F);
    chk("rst_last", 0, bus0.last_grant, 1);
    req0 = 1'b1; a0 = 7'h5A; d0 = 8'hC3;
    t = 0;
    do begin tick(); t++; end while (!bus0.go_out && t < 50);
    chk("s1_latency", 0, t, 1);
    chk("s1_ack0", 0, bus0.ack0, 1);
    chk("s1_a_out", 0, bus0.a_out, 7'h5A);
    chk("s1_d_out", 0, bus0.d_out, 8'hC3);
    req0 = 1'b0;
    repeat (20) tick();
    chk("s1_no_done_early", 0, bus0.done0, 0);
    tick();
    chk("s1_done0_at_21", 0, bus0.done0, 1);
    tick();
    chk("s1_busy_at_22", 0, bus0.busy, 1);
    tick();
    chk("s1_busy_at_23", 0, bus0.busy, 0);

    // Both requesters held from reset: alternating grants.
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; a0 = 7'h11; d0 = 8'h22; a1 = 7'h33; d1 = 8'h44;
    hold_reset(2);
    ng = 0; n1 = 0; d1t = -1; t = 0;
    while (ng < 4 && t < 150) begin
      tick(); t++;
      if (bus0.go_out) begin gt[ng] = t; gw[ng] = bus0.last_grant; ng++; end
      if (bus1.go_out && n1 < 2) begin g1t[n1] = t; n1++; end
      if ((bus1.done0 || bus1.done1) && d1t < 0) d1t = t;
    end
    chk("rr_grants", 0, ng, 4);
    if (ng == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", 0, gw[k], k % 2);
      for (int k = 1; k < 4; k++) chk("rr_spacing", 0, gt[k] - gt[k-1], 24);
    end
    chk("short_grants", 1, n1, 2);
    if (n1 == 2) begin
      chk("short_spacing", 1, g1t[1] - g1t[0], 5);
      chk("short_done", 1, d1t - g1t[0], 3);
    end
    req0 = 1'b0; req1 = 1'b0;

    // req1 alone for three transactions.
    wait_idle0();
    req1 = 1'b1; a1 = 7'h2B; d1 = 8'h9E;
    na0 = 0; na1 = 0; t = 0;
    while (na1 < 3 && t < 120) begin
      tick(); t++;
      if (bus0.ack0) na0++;
      if (bus0.ack1) na1++;
    end
    req1 = 1'b0;
    chk("r1_acks", 0, na1, 3);
    chk("r1_no_ack0", 0, na0, 0);

    // req0 pulsed during SHIFT is lost.
    wait_idle0();
    req0 = 1'b1; a0 = 7'h01; d0 = 8'h02;
    t = 0;
    do begin tick(); t++; end while (!bus0.ack0 && t < 50);
    req0 = 1'b0;
    repeat (5) tick();
    req0 = 1'b1; a0 = 7'h4C;
    tick();
    req0 = 1'b0;
    ngo = 0; na0 = 0;
    repeat (40) begin
      tick();
      if (bus0.go_out) ngo++;
      if (bus0.ack0) na0++;
    end
    chk("pulse_no_go", 0, ngo, 0);
    chk("pulse_no_ack0", 0, na0, 0);

    // Reset 10 cycles into SHIFT aborts the frame.
    wait_idle0();
    req0 = 1'b1; a0 = 7'h6E; d0 = 8'h5D;
    t = 0;
    do begin tick(); t++; end while (!bus0.go_out && t < 50);
    req0 = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("abort_go", 0, bus0.go_out, 0);
    chk("abort_busy", 0, bus0.busy, 0);
    chk("abort_a_out", 0, bus0.a_out, 7'h7F);
    chk("abort_d_out", 0, bus0.d_out, 8'hFF);
    chk("abort_last", 0, bus0.last_grant, 1);
    repeat (2) tick();
    rst = 1'b0; req1 = 1'b1; a1 = 7'h33; d1 = 8'hA5;
    tick();
    chk("post_rst_go", 0, bus0.go_out, 1);
    chk("post_rst_ack1", 0, bus0.ack1, 1);
    chk("post_rst_a_out", 0, bus0.a_out, 7'h33);
    req1 = 1'b0;
    ngo = 0;
    repeat (30) begin tick(); if (bus0.done0) ngo++; end
    chk("abort_no_done0", 0, ngo, 0);

    // Randomized traffic, occasional reset.
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst  = ($urandom_range(0, 299) == 0);
      req0 = ($urandom_range(0, 3) == 0);
      req1 = ($urandom_range(0, 3) == 0);
      a0 = 7'($urandom); a1 = 7'($urandom);
      d0 = 8'($urandom); d1 = 8'($urandom);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
